ram_clear_ctrl: RTL and testbench
=================================

Name: ram_clear_ctrl

Overview:
- Sequences whole-memory clearing of SDRAM and DDR3 while the menu core runs, so the next core starts with clean RAM.
- Generates one shared address stream and drives the write strobes of the SDRAM controller and the DDR3 bridge. Handles each target's accept handshake and paces issue with a programmable gap.
- Sits between the PLL-lock/reset logic and the sdram/ddram write ports. Write data is fixed zero outside this block.

Parameters:
- SDR_AW, 25, SDRAM word-address width; SDRAM is cleared over addresses 0..2^SDR_AW-1.
- DDR_AW, 28, DDR3 word-address width; DDR3 is cleared over addresses 0..2^DDR_AW-1.
- GAP, 8, idle cycles between completing one address and issuing the next (0 allowed).

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begin a clear pass.
- abort  in  1  level; stop the pass immediately.
- pll_locked  in  1  memory clocks stable.
- sdr_we  out  1  SDRAM write request, held until acknowledged.
- sdr_addr  out  SDR_AW  SDRAM word address.
- sdr_ack  in  1  SDRAM accepted the current write (one-cycle pulse).
- ddr_we  out  1  DDR3 write request (Avalon style), held while ddr_busy.
- ddr_addr  out  DDR_AW  DDR3 word address.
- ddr_busy  in  1  DDR3 waitrequest.
- busy  out  1  a pass is in progress.
- done  out  1  sticky: the last pass completed fully.
- progress  out  8  top 8 bits of the shared address counter.

Behaviour:
- Reset: RESET low on a clk_sys edge puts the FSM in IDLE and clears all outputs and internal counters/flags to 0. Reset mid-pass abandons the pass; done=0.
- Shared counter: addr, width CW=max(SDR_AW,DDR_AW). sdr_addr=addr[SDR_AW-1:0], ddr_addr=addr[DDR_AW-1:0].
  - sdr_active = (addr < 2^SDR_AW); ddr_active = (addr < 2^DDR_AW).
- FSM states: IDLE, WAIT_LOCK, ISSUE, GAP_WAIT, DONE.
- IDLE:
  - start & pll_locked -> ISSUE, with addr=0, done=0, busy=1.
  - start & ~pll_locked -> WAIT_LOCK, with busy=1 and done=0.
- WAIT_LOCK: pll_locked -> ISSUE with addr=0.
- ISSUE:
  - sdr_we=sdr_active & ~sdr_ok. An SDRAM write completes in the cycle sdr_ack=1 while sdr_we=1; that cycle sets sdr_ok.
  - ddr_we=ddr_active & ~ddr_ok. A DDR3 write completes in the cycle ddr_we=1 & ddr_busy=0; that cycle sets ddr_ok.
  - An inactive target counts as ok.
  - When both are ok (same-cycle completion allowed): clear both flags and deassert the strobes next cycle.
    - If addr == 2^CW-1 -> DONE.
    - Else if GAP=0 -> addr+1, stay in ISSUE.
    - Else -> GAP_WAIT with gap_cnt=GAP-1.
- GAP_WAIT: decrement gap_cnt; at 0 -> addr+1 -> ISSUE. Exactly GAP cycles with both strobes low.
- DONE: busy=0, done=1 -> IDLE next cycle. done stays 1 until the next accepted start or RESET.
- Minimum latency per address: 1 issue cycle (ack/accept in that cycle) + GAP.
- Ignored events:
  - start while busy is ignored.
  - sdr_ack while sdr_we=0 is ignored.
- Strobe stability: sdr_addr and ddr_addr are stable while the corresponding we is high.
- abort (highest priority after reset), in any non-IDLE state: next cycle FSM=IDLE, we strobes=0, busy=0, done=0, addr retained for progress.
  - abort and start in the same cycle: abort wins.
- pll_locked falling during ISSUE/GAP_WAIT: hold current strobes unchanged (no re-issue), continue.
- No wrap-around: the counter never increments past 2^CW-1.

Decomposition:
- Shared package ram_clear_pkg holds:
  - the state enum (IDLE, WAIT_LOCK, ISSUE, GAP_WAIT, DONE);
  - the function clog/max for CW.
- One sub-module, clear_port_hs: per-target request/ok-flag handshake, instantiated twice (ack mode for SDRAM, waitrequest mode for DDR3).
- The FSM, counter and gap timer stay in ram_clear_ctrl.

Test Plan:
- Basic pass (SDR_AW=4, DDR_AW=3, GAP=2; sdr_ack same cycle, ddr_busy=0), start -> 8 paired writes at addr 0..7, then 8 SDRAM-only writes 8..15; 2 idle cycles between; done=1, busy=0 after addr 15.
- Backpressure: ddr_busy=1 for 5 cycles at addr 3 -> ddr_we and ddr_addr=3 held 6 cycles; sdr_we drops after its ack; addr 4 issued only after DDR accepts plus 2 gap cycles.
- Lock gating: start with pll_locked=0 -> WAIT_LOCK, no strobes, busy=1; raise pll_locked -> first write at addr 0 next cycle.
- Abort: abort asserted during GAP_WAIT at addr 5 -> next cycle busy=0, done=0, strobes 0; new start restarts at addr 0.
- Reset mid-pass: RESET=0 for 1 cycle at addr 6 in ISSUE -> all outputs 0, FSM IDLE; start ignored during busy and does not reset addr.
- GAP=0, SDR_AW=DDR_AW=3: 8 addresses in 8 cycles with both strobes continuously high, progress incrementing each cycle, done after addr 7.

Source files
------------

// File: rtl/ram_clear_pkg.sv
// Shared types and elaboration helpers for the RAM clear controller.
package ram_clear_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLock,
        StIssue,
        StGapWait,
        StDone
    } clr_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..v, never less than 1.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 1;
        while (r < 32 && (64'd1 << r) <= 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/clear_port_hs.sv
// Per-target write request with a sticky "accepted" flag; AckMode selects
// ack-pulse handshake (1) or Avalon waitrequest handshake (0).
module clear_port_hs #(
    parameter bit AckMode = 1'b1
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic issue,
    input  logic active,
    input  logic clr,
    input  logic resp,
    output logic we,
    output logic ok
);

    logic ok_q;
    logic ok_d;
    logic fire;

    always_comb begin
        we   = issue & active & ~ok_q;
        fire = we & (AckMode ? resp : ~resp);
        // An inactive target never gets a strobe but must not stall the pass.
        ok   = ok_q | fire | ~active;
        ok_d = clr ? 1'b0 : (ok_q | fire);
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            ok_q <= 1'b0;
        end else begin
            ok_q <= ok_d;
        end
    end

endmodule

// File: rtl/ram_clear_ctrl.sv
// Whole-memory zero-fill sequencer for SDRAM and DDR3 driven from one shared
// address counter with a programmable inter-address gap.
module ram_clear_ctrl
    import ram_clear_pkg::*;
#(
    parameter int unsigned SDR_AW = 25,
    parameter int unsigned DDR_AW = 28,
    parameter int unsigned GAP    = 8
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic              pll_locked,
    output logic              sdr_we,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_ack,
    output logic              ddr_we,
    output logic [DDR_AW-1:0] ddr_addr,
    input  logic              ddr_busy,
    output logic              busy,
    output logic              done,
    output logic [7:0]        progress
);

    localparam int unsigned CW = max_u(SDR_AW, DDR_AW);
    localparam int unsigned GW = clog2_min1(GAP);

    localparam logic [CW:0]   SdrLim  = (CW+1)'(64'd1 << SDR_AW);
    localparam logic [CW:0]   DdrLim  = (CW+1)'(64'd1 << DDR_AW);
    localparam logic [CW-1:0] AddrMax = '1;

    clr_state_e    state_q, state_d;
    logic [CW-1:0] addr_q, addr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;

    logic in_issue;
    logic sdr_active, ddr_active;
    logic sdr_ok, ddr_ok;
    logic both_ok;
    logic flag_clr;

    assign in_issue   = (state_q == StIssue);
    assign sdr_active = ({1'b0, addr_q} < SdrLim);
    assign ddr_active = ({1'b0, addr_q} < DdrLim);
    assign both_ok    = in_issue & sdr_ok & ddr_ok;
    // Flags only matter inside ISSUE; clearing elsewhere also covers abort.
    assign flag_clr   = both_ok | ~in_issue;

    clear_port_hs #(
        .AckMode (1'b1)
    ) u_sdr_hs (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .issue   (in_issue),
        .active  (sdr_active),
        .clr     (flag_clr),
        .resp    (sdr_ack),
        .we      (sdr_we),
        .ok      (sdr_ok)
    );

    clear_port_hs #(
        .AckMode (1'b0)
    ) u_ddr_hs (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .issue   (in_issue),
        .active  (ddr_active),
        .clr     (flag_clr),
        .resp    (ddr_busy),
        .we      (ddr_we),
        .ok      (ddr_ok)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        done_d  = done_q;

        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        done_d = 1'b0;
                        if (pll_locked) begin
                            state_d = StIssue;
                            addr_d  = '0;
                        end else begin
                            state_d = StWaitLock;
                        end
                    end
                end
                StWaitLock: begin
                    if (pll_locked) begin
                        state_d = StIssue;
                        addr_d  = '0;
                    end
                end
                StIssue: begin
                    if (both_ok) begin
                        if (addr_q == AddrMax) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (GAP == 0) begin
                            addr_d = addr_q + 1'b1;
                        end else begin
                            state_d = StGapWait;
                            gap_d   = GW'(GAP - 1);
                        end
                    end
                end
                StGapWait: begin
                    if (gap_q == '0) begin
                        state_d = StIssue;
                        addr_d  = addr_q + 1'b1;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == StWaitLock) || (state_q == StIssue) || (state_q == StGapWait);
    assign done     = done_q;
    assign sdr_addr = addr_q[SDR_AW-1:0];
    assign ddr_addr = addr_q[DDR_AW-1:0];

    generate
        if (CW >= 8) begin : g_prog_top
            assign progress = addr_q[CW-1 -: 8];
        end else begin : g_prog_ext
            assign progress = 8'(addr_q);
        end
    endgenerate

endmodule

// File: tb/tb_ram_clear_ctrl.sv
// Directed bench: small-geometry instance with GAP=2 plus a GAP=0 instance.
module tb_ram_clear_ctrl;

    logic clk_sys = 1'b0;
    logic RESET;
    always #5 clk_sys = ~clk_sys;

    logic       a_start, a_abort, a_lock, a_ddr_busy;
    logic       a_sdr_we, a_ddr_we, a_busy, a_done;
    logic [3:0] a_sdr_addr;
    logic [2:0] a_ddr_addr;
    logic [7:0] a_progress;
    wire logic  a_sdr_ack = a_sdr_we;

    logic       b_start, b_abort, b_lock, b_ddr_busy;
    logic       b_sdr_we, b_ddr_we, b_busy, b_done;
    logic [2:0] b_sdr_addr;
    logic [2:0] b_ddr_addr;
    logic [7:0] b_progress;
    wire logic  b_sdr_ack = b_sdr_we;

    ram_clear_ctrl #(.SDR_AW(4), .DDR_AW(3), .GAP(2)) u_dut_a (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .start      (a_start),
        .abort      (a_abort),
        .pll_locked (a_lock),
        .sdr_we     (a_sdr_we),
        .sdr_addr   (a_sdr_addr),
        .sdr_ack    (a_sdr_ack),
        .ddr_we     (a_ddr_we),
        .ddr_addr   (a_ddr_addr),
        .ddr_busy   (a_ddr_busy),
        .busy       (a_busy),
        .done       (a_done),
        .progress   (a_progress)
    );

    ram_clear_ctrl #(.SDR_AW(3), .DDR_AW(3), .GAP(0)) u_dut_b (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .start      (b_start),
        .abort      (b_abort),
        .pll_locked (b_lock),
        .sdr_we     (b_sdr_we),
        .sdr_addr   (b_sdr_addr),
        .sdr_ack    (b_sdr_ack),
        .ddr_we     (b_ddr_we),
        .ddr_addr   (b_ddr_addr),
        .ddr_busy   (b_ddr_busy),
        .busy       (b_busy),
        .done       (b_done),
        .progress   (b_progress)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_idle_a(input string tag, input logic exp_done, input int exp_prog);
        check({tag, ".busy"}, 32'(a_busy), 32'd0);
        check({tag, ".done"}, 32'(a_done), 32'(exp_done));
        check({tag, ".we"}, {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
        check({tag, ".prog"}, 32'(a_progress), 32'(exp_prog));
    endtask

    initial begin
        RESET = 1'b0;
        a_start = 0; a_abort = 0; a_lock = 1; a_ddr_busy = 0;
        b_start = 0; b_abort = 0; b_lock = 1; b_ddr_busy = 0;
        tick(); tick();
        RESET = 1'b1;
        check_idle_a("reset", 1'b0, 0);
        check("reset.b_busy", 32'(b_busy), 32'd0);

        // Basic pass: 8 paired writes then 8 SDRAM-only, 2 gap cycles between.
        a_start = 1; tick(); a_start = 0;
        check("basic.busy", 32'(a_busy), 32'd1);
        check("basic.done0", 32'(a_done), 32'd0);
        for (int a = 0; a < 16; a++) begin
            check($sformatf("basic.sdr_we@%0d", a), 32'(a_sdr_we), 32'd1);
            check($sformatf("basic.sdr_addr@%0d", a), 32'(a_sdr_addr), 32'(a));
            check($sformatf("basic.ddr_we@%0d", a), 32'(a_ddr_we), (a < 8) ? 32'd1 : 32'd0);
            check($sformatf("basic.prog@%0d", a), 32'(a_progress), 32'(a));
            if (a < 8) check($sformatf("basic.ddr_addr@%0d", a), 32'(a_ddr_addr), 32'(a));
            tick();
            if (a < 15) begin
                check($sformatf("basic.gap1@%0d", a), {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
                tick();
                check($sformatf("basic.gap2@%0d", a), {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
                tick();
            end
        end
        check_idle_a("basic.end", 1'b1, 15);
        tick();
        check_idle_a("basic.sticky", 1'b1, 15);

        // Backpressure on DDR at address 3.
        a_start = 1; tick(); a_start = 0;
        check("bp.done_clr", 32'(a_done), 32'd0);
        repeat (9) tick();
        check("bp.addr3", 32'(a_sdr_addr), 32'd3);
        a_ddr_busy = 1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.ddr_we%0d", i), 32'(a_ddr_we), 32'd1);
            check($sformatf("bp.ddr_addr%0d", i), 32'(a_ddr_addr), 32'd3);
            check($sformatf("bp.sdr_we%0d", i), 32'(a_sdr_we), (i == 0) ? 32'd1 : 32'd0);
            tick();
        end
        a_ddr_busy = 0;
        check("bp.ddr_we5", 32'(a_ddr_we), 32'd1);
        check("bp.ddr_addr5", 32'(a_ddr_addr), 32'd3);
        check("bp.sdr_we5", 32'(a_sdr_we), 32'd0);
        tick();
        check("bp.gap1", {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
        tick();
        check("bp.gap2", {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
        tick();
        check("bp.next_we", {30'd0, a_sdr_we, a_ddr_we}, 32'd3);
        check("bp.next_addr", 32'(a_sdr_addr), 32'd4);

        // Abort during GAP_WAIT at address 5.
        repeat (3) tick();
        check("abort.addr5", 32'(a_progress), 32'd5);
        tick();
        a_abort = 1; tick(); a_abort = 0;
        check_idle_a("abort.now", 1'b0, 5);
        tick();
        check("abort.stays", 32'(a_busy), 32'd0);
        a_start = 1; tick(); a_start = 0;
        check("abort.restart_we", 32'(a_sdr_we), 32'd1);
        check("abort.restart_addr", 32'(a_sdr_addr), 32'd0);

        // Abort and start together: abort wins, no new pass.
        a_abort = 1; a_start = 1; tick(); a_abort = 0; a_start = 0;
        check("abst.busy0", 32'(a_busy), 32'd0);
        tick();
        check("abst.busy1", 32'(a_busy), 32'd0);

        // Lock gating.
        a_lock = 0;
        a_start = 1; tick(); a_start = 0;
        check("lock.busy", 32'(a_busy), 32'd1);
        check("lock.we", {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
        tick(); tick();
        check("lock.wait_busy", 32'(a_busy), 32'd1);
        check("lock.wait_we", {30'd0, a_sdr_we, a_ddr_we}, 32'd0);
        a_lock = 1; tick();
        check("lock.first_we", {30'd0, a_sdr_we, a_ddr_we}, 32'd3);
        check("lock.first_addr", 32'(a_sdr_addr), 32'd0);

        // Reset in ISSUE at address 6.
        repeat (18) tick();
        check("rst.addr6", 32'(a_sdr_addr), 32'd6);
        check("rst.we6", 32'(a_sdr_we), 32'd1);
        RESET = 0; tick(); RESET = 1;
        check_idle_a("rst.after", 1'b0, 0);

        // Start while busy is ignored and does not rewind the counter.
        a_start = 1; tick(); a_start = 0;
        repeat (3) tick();
        check("ign.addr1", 32'(a_sdr_addr), 32'd1);
        a_start = 1; tick(); a_start = 0;
        check("ign.busy", 32'(a_busy), 32'd1);
        check("ign.prog", 32'(a_progress), 32'd1);
        tick(); tick();
        check("ign.addr2", 32'(a_sdr_addr), 32'd2);
        check("ign.we2", 32'(a_sdr_we), 32'd1);
        a_abort = 1; tick(); a_abort = 0;

        // GAP=0: one address per cycle with strobes held high.
        b_start = 1; tick(); b_start = 0;
        for (int a = 0; a < 8; a++) begin
            check($sformatf("g0.we@%0d", a), {30'd0, b_sdr_we, b_ddr_we}, 32'd3);
            check($sformatf("g0.prog@%0d", a), 32'(b_progress), 32'(a));
            check($sformatf("g0.ddr_addr@%0d", a), 32'(b_ddr_addr), 32'(a));
            tick();
        end
        check("g0.busy", 32'(b_busy), 32'd0);
        check("g0.done", 32'(b_done), 32'd1);
        check("g0.we_end", {30'd0, b_sdr_we, b_ddr_we}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
